// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A-compatible command-write sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_e;

  // Captured bus write: address bit plus data byte.
  typedef struct packed {
    logic       a0;
    logic [7:0] d;
  } wr_cap_t;

  // ICW1 / OCW bit positions (a0=0 command byte)
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int CMD_SEL   = 4;  // 1 = ICW1, 0 = OCW2/OCW3
  localparam int OCW_SEL3  = 3;  // with CMD_SEL=0: 0 = OCW2, 1 = OCW3
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

  // OCW2 {R,SL,EOI} command codes
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

endpackage

// File: rtl/pic_write_strobe.sv
// Write-strobe edge detect: latches {a0,din} while the write is active and
// raises commit for the single cycle after the strobe ends.
module pic_write_strobe
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       cs_bar,
  input  logic       wr_bar,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       commit,
  output logic       a0_c,
  output logic [7:0] d_c
);

  logic    wr_act;
  logic    wr_q;
  wr_cap_t cap_q;

  assign wr_act = !cs_bar && !wr_bar;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_q  <= 1'b0;
      cap_q <= '0;
    end else begin
      wr_q <= wr_act;
      if (wr_act) cap_q <= '{a0: a0, d: din};
    end
  end

  // cs_bar rising with wr_bar still low also drops wr_act, so it commits too.
  assign commit = wr_q && !wr_act;
  assign a0_c   = cap_q.a0;
  assign d_c    = cap_q.d;

endmodule

// File: rtl/pic_init_sequencer.sv
// ICW/OCW decoder and initialization FSM; holds the configuration registers
// and issues one-cycle command pulses to the resolver, ISR/IRR and cascade logic.
module pic_init_sequencer
  import pic_pkg::*;
#(
  parameter bit         SUPPORT_CASCADE = 1'b1,
  parameter logic [4:0] VECTOR_RESET    = 5'h00
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       cs_bar,
  input  logic       wr_bar,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       init_done,
  output logic       init_stb,
  output logic       ltim,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic [4:0] icw4_cfg,
  output logic [7:0] imr,
  output logic       ocw2_stb,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr,
  output logic       poll_stb,
  output logic       smm
);

  logic       commit;
  logic       a0_c;
  logic [7:0] d_c;

  pic_write_strobe u_wr (
    .clk       (clk),
    .reset_bar (reset_bar),
    .cs_bar    (cs_bar),
    .wr_bar    (wr_bar),
    .a0        (a0),
    .din       (din),
    .commit    (commit),
    .a0_c      (a0_c),
    .d_c       (d_c)
  );

  pic_state_e state_q, state_d;
  logic       sngl_q, ic4_q, single_eff;
  logic       ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_imr, ld_ocw2, ld_ocw3;

  // Without cascade support every ICW1 behaves as single mode.
  assign single_eff = sngl_q || !SUPPORT_CASCADE;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) state_q <= ST_UNINIT;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_icw1 = 1'b0;
    ld_icw2 = 1'b0;
    ld_icw3 = 1'b0;
    ld_icw4 = 1'b0;
    ld_imr  = 1'b0;
    ld_ocw2 = 1'b0;
    ld_ocw3 = 1'b0;
    if (commit) begin
      if (!a0_c && d_c[CMD_SEL]) begin
        ld_icw1 = 1'b1;
        state_d = ST_WAIT_ICW2;
      end else begin
        // a0=0 OCW patterns fall through untouched while initializing.
        case (state_q)
          ST_WAIT_ICW2: if (a0_c) begin
            ld_icw2 = 1'b1;
            if (!single_eff) state_d = ST_WAIT_ICW3;
            else if (ic4_q)  state_d = ST_WAIT_ICW4;
            else             state_d = ST_READY;
          end
          ST_WAIT_ICW3: if (a0_c) begin
            ld_icw3 = 1'b1;
            state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: if (a0_c) begin
            ld_icw4 = 1'b1;
            state_d = ST_READY;
          end
          ST_READY: begin
            if (a0_c)               ld_imr  = 1'b1;
            else if (!d_c[OCW_SEL3]) ld_ocw2 = 1'b1;
            else                    ld_ocw3 = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      ltim        <= 1'b0;
      vector_base <= VECTOR_RESET;
      cascade_cfg <= '0;
      icw4_cfg    <= '0;
      imr         <= '0;
      ocw2_cmd    <= '0;
      ocw2_level  <= '0;
      read_isr    <= 1'b0;
      smm         <= 1'b0;
      init_stb    <= 1'b0;
      ocw2_stb    <= 1'b0;
      poll_stb    <= 1'b0;
    end else begin
      init_stb <= ld_icw1;
      ocw2_stb <= ld_ocw2;
      poll_stb <= ld_ocw3 && d_c[OCW3_P];
      if (ld_icw1) begin
        ltim     <= d_c[ICW1_LTIM];
        sngl_q   <= d_c[ICW1_SNGL];
        ic4_q    <= d_c[ICW1_IC4];
        imr      <= '0;
        smm      <= 1'b0;
        read_isr <= 1'b0;
        if (!d_c[ICW1_IC4]) icw4_cfg <= '0;
        if (d_c[ICW1_SNGL] || !SUPPORT_CASCADE) cascade_cfg <= '0;
      end
      if (ld_icw2) vector_base <= d_c[7:3];
      if (ld_icw3) cascade_cfg <= SUPPORT_CASCADE ? d_c : 8'h00;
      if (ld_icw4) icw4_cfg    <= d_c[4:0];
      if (ld_imr)  imr         <= d_c;
      if (ld_ocw2) begin
        ocw2_cmd   <= d_c[7:5];
        ocw2_level <= d_c[2:0];
      end
      if (ld_ocw3) begin
        if (d_c[OCW3_RR])   read_isr <= d_c[OCW3_RIS];
        if (d_c[OCW3_ESMM]) smm      <= d_c[OCW3_SMM];
      end
    end
  end

  assign init_done = (state_q == ST_READY);

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench: one cascade-capable instance and one single-only instance
// share the same write stream; expected values are hand-computed.
module tb_pic_init_sequencer;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic reset_bar = 1'b0;
  logic cs_bar = 1'b1, wr_bar = 1'b1, a0 = 1'b0;
  logic [7:0] din = 8'h00;

  logic       init_done0, init_stb0, ltim0, ocw2_stb0, read_isr0, poll_stb0, smm0;
  logic [4:0] vector_base0, icw4_cfg0;
  logic [7:0] cascade_cfg0, imr0;
  logic [2:0] ocw2_cmd0, ocw2_level0;

  logic       init_done1, init_stb1, ltim1, ocw2_stb1, read_isr1, poll_stb1, smm1;
  logic [4:0] vector_base1, icw4_cfg1;
  logic [7:0] cascade_cfg1, imr1;
  logic [2:0] ocw2_cmd1, ocw2_level1;

  int passed = 0;
  int total = 0;
  int commit_cnt = 0;
  int c0;

  always #5 clk = ~clk;

  pic_init_sequencer #(.SUPPORT_CASCADE(1'b1), .VECTOR_RESET(5'h1F)) dut0 (
    .clk(clk), .reset_bar(reset_bar), .cs_bar(cs_bar), .wr_bar(wr_bar), .a0(a0), .din(din),
    .init_done(init_done0), .init_stb(init_stb0), .ltim(ltim0), .vector_base(vector_base0),
    .cascade_cfg(cascade_cfg0), .icw4_cfg(icw4_cfg0), .imr(imr0), .ocw2_stb(ocw2_stb0),
    .ocw2_cmd(ocw2_cmd0), .ocw2_level(ocw2_level0), .read_isr(read_isr0),
    .poll_stb(poll_stb0), .smm(smm0)
  );

  pic_init_sequencer #(.SUPPORT_CASCADE(1'b0), .VECTOR_RESET(5'h00)) dut1 (
    .clk(clk), .reset_bar(reset_bar), .cs_bar(cs_bar), .wr_bar(wr_bar), .a0(a0), .din(din),
    .init_done(init_done1), .init_stb(init_stb1), .ltim(ltim1), .vector_base(vector_base1),
    .cascade_cfg(cascade_cfg1), .icw4_cfg(icw4_cfg1), .imr(imr1), .ocw2_stb(ocw2_stb1),
    .ocw2_cmd(ocw2_cmd1), .ocw2_level(ocw2_level1), .read_isr(read_isr1),
    .poll_stb(poll_stb1), .smm(smm1)
  );

  always @(posedge clk) if (dut0.commit) commit_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a write for n cycles; return #1 after the edge that applies the commit.
  task automatic wr(input logic a, input logic [7:0] d, input int n);
    @(negedge clk);
    cs_bar = 1'b0; wr_bar = 1'b0; a0 = a; din = d;
    repeat (n) @(negedge clk);
    cs_bar = 1'b1; wr_bar = 1'b1; din = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // 1: reset state, UNINIT ignores OCW1
    repeat (3) @(negedge clk);
    chk("rst_state", dut0.state_q, ST_UNINIT);
    chk("rst_init_done", init_done0, 1'b0);
    chk("rst_imr", imr0, 8'h00);
    chk("rst_vector_base", vector_base0, 5'h1F);
    reset_bar = 1'b1;
    wr(1'b1, 8'hFF, 1);
    chk("uninit_ocw1_imr", imr0, 8'h00);
    chk("uninit_state", dut0.state_q, ST_UNINIT);

    // 2: single + IC4
    wr(1'b0, 8'h13, 1);
    chk("icw1_init_stb", init_stb0, 1'b1);
    chk("icw1_state", dut0.state_q, ST_WAIT_ICW2);
    next_cycle();
    chk("icw1_init_stb_low", init_stb0, 1'b0);
    wr(1'b1, 8'h20, 1);
    chk("icw2_vector_base", vector_base0, 5'h04);
    chk("icw2_not_done", init_done0, 1'b0);
    wr(1'b1, 8'h01, 1);
    chk("icw4_cfg", icw4_cfg0, 5'h01);
    chk("icw4_init_done", init_done0, 1'b1);
    chk("nc_icw4_init_done", init_done1, 1'b1);

    // 3: cascaded + IC4; the non-cascade instance takes ICW3 slot as ICW4
    wr(1'b0, 8'h11, 1);
    wr(1'b1, 8'h08, 1);
    chk("casc_state_icw3", dut0.state_q, ST_WAIT_ICW3);
    chk("nc_state_icw4", dut1.state_q, ST_WAIT_ICW4);
    chk("casc_vector_base", vector_base0, 5'h01);
    wr(1'b1, 8'h04, 1);
    chk("casc_cascade_cfg", cascade_cfg0, 8'h04);
    chk("casc_not_done", init_done0, 1'b0);
    chk("nc_icw4_cfg", icw4_cfg1, 5'h04);
    chk("nc_done", init_done1, 1'b1);
    wr(1'b1, 8'h03, 1);
    chk("casc_icw4_cfg", icw4_cfg0, 5'h03);
    chk("casc_done", init_done0, 1'b1);
    chk("nc_imr", imr1, 8'h03);
    chk("nc_cascade_cfg", cascade_cfg1, 8'h00);

    // 4: operational commands
    wr(1'b1, 8'hA5, 1);
    chk("ocw1_imr", imr0, 8'hA5);
    wr(1'b0, 8'h60, 1);
    chk("ocw2_stb", ocw2_stb0, 1'b1);
    chk("ocw2_cmd", ocw2_cmd0, OCW2_SP_EOI);
    chk("ocw2_level", ocw2_level0, 3'd0);
    next_cycle();
    chk("ocw2_stb_low", ocw2_stb0, 1'b0);
    chk("ocw2_cmd_held", ocw2_cmd0, 3'b011);
    wr(1'b0, 8'h0B, 1);
    chk("ocw3_read_isr", read_isr0, 1'b1);
    wr(1'b0, 8'h0C, 1);
    chk("ocw3_poll_stb", poll_stb0, 1'b1);
    chk("ocw3_read_isr_kept", read_isr0, 1'b1);
    next_cycle();
    chk("ocw3_poll_stb_low", poll_stb0, 1'b0);
    wr(1'b0, 8'h68, 1);
    chk("ocw3_smm", smm0, 1'b1);

    // 5: ICW1 from READY restarts the sequence
    wr(1'b0, 8'h13, 1);
    chk("reinit_imr", imr0, 8'h00);
    chk("reinit_smm", smm0, 1'b0);
    chk("reinit_read_isr", read_isr0, 1'b0);
    chk("reinit_init_done", init_done0, 1'b0);
    chk("reinit_icw4_kept", icw4_cfg0, 5'h03);
    chk("reinit_cascade_clr", cascade_cfg0, 8'h00);
    wr(1'b0, 8'h60, 1);
    chk("wait_ocw2_no_stb", ocw2_stb0, 1'b0);
    chk("wait_ocw2_state", dut0.state_q, ST_WAIT_ICW2);

    // 6: long write commits once; reset mid-sequence
    c0 = commit_cnt;
    wr(1'b1, 8'h20, 5);
    chk("held_single_commit", commit_cnt - c0, 1);
    chk("held_state", dut0.state_q, ST_WAIT_ICW4);
    @(negedge clk);
    reset_bar = 1'b0;
    #1;
    chk("midrst_state", dut0.state_q, ST_UNINIT);
    chk("midrst_vector_base", vector_base0, 5'h1F);
    chk("midrst_icw4_cfg", icw4_cfg0, 5'h00);
    chk("midrst_init_done", init_done0, 1'b0);
    @(negedge clk);
    reset_bar = 1'b1;
    wr(1'b1, 8'h01, 1);
    chk("post_rst_icw4_ignored", icw4_cfg0, 5'h00);
    chk("post_rst_imr", imr0, 8'h00);
    chk("post_rst_state", dut0.state_q, ST_UNINIT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
